// File: rtl/icache_direct.sv
// Direct-mapped read-only I-cache: 1-cycle hit, word-by-word line refill via MemCtl.
// Backpressure: rdy low freezes everything; optional hit/miss counters under ICACHE_STAT_EN.
module icache_direct #(
   parameter int INDEX_BITS     = 6,
   parameter int LINE_WORDS_LOG = 2,
   parameter int TAG_BITS       = 32 - 2 - LINE_WORDS_LOG - INDEX_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        ret_flg,
   output logic [31:0] ret_inst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_flg,
   input  logic [31:0] mem_res
`ifdef ICACHE_STAT_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);

   localparam int LINES  = 1 << INDEX_BITS;
   localparam int WORDS  = 1 << LINE_WORDS_LOG;
   localparam int IDX_LO = 2 + LINE_WORDS_LOG;
   localparam int TAG_LO = IDX_LO + INDEX_BITS;

   typedef enum logic [0:0] {IDLE, REFILL} state_t;

   state_t state, state_n;

   logic [31:0]              data_arr [LINES*WORDS];
   logic [TAG_BITS-1:0]      tag_arr  [LINES];
   logic [LINES-1:0]         valid;

   logic [LINE_WORDS_LOG-1:0] cnt, cnt_inc, lat_off;
   logic [INDEX_BITS-1:0]     lat_idx;
   logic [TAG_BITS-1:0]       lat_tag;
   logic [31:0]               crit;

   logic [LINE_WORDS_LOG-1:0] if_off;
   logic [INDEX_BITS-1:0]     if_idx;
   logic [TAG_BITS-1:0]       if_tag;
   logic                      hit, fetch_ok, do_hit, do_miss, refill_wr, last;

   assign if_off    = if_addr[IDX_LO-1:2];
   assign if_idx    = if_addr[TAG_LO-1:IDX_LO];
   assign if_tag    = if_addr[31:TAG_LO];
   assign hit       = valid[if_idx] && (tag_arr[if_idx] == if_tag);
   // The cycle after a response never samples if_req, so IF has time to move on.
   assign fetch_ok  = rdy && !reset && (state == IDLE) && if_req && !ret_flg;
   assign do_hit    = fetch_ok && hit;
   assign do_miss   = fetch_ok && !hit;
   assign refill_wr = rdy && !reset && (state == REFILL) && mem_flg;
   assign last      = (cnt == {LINE_WORDS_LOG{1'b1}});
   assign cnt_inc   = cnt + LINE_WORDS_LOG'(1);

   always_comb begin
      state_n = state;
      case (state)
         IDLE:   if (do_miss) state_n = REFILL;
         REFILL: begin
            if (rdy && reset)             state_n = IDLE;
            else if (refill_wr && last)   state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid    <= '0;
         cnt      <= '0;
         lat_off  <= '0;
         lat_idx  <= '0;
         lat_tag  <= '0;
         crit     <= '0;
         ret_flg  <= 1'b0;
         ret_inst <= '0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
      end else if (rdy) begin
         ret_flg <= 1'b0;
         if (state == IDLE) begin
            if (do_hit) begin
               ret_flg  <= 1'b1;
               ret_inst <= data_arr[{if_idx, if_off}];
            end else if (do_miss) begin
               valid[if_idx] <= 1'b0;
               lat_tag  <= if_tag;
               lat_idx  <= if_idx;
               lat_off  <= if_off;
               cnt      <= '0;
               mem_addr <= {if_addr[31:IDX_LO], {LINE_WORDS_LOG{1'b0}}, 2'b00};
               mem_req  <= 1'b1;
            end
         end else if (reset) begin
            mem_req <= 1'b0;
         end else if (mem_flg) begin
            if (cnt == lat_off) crit <= mem_res;
            if (last) begin
               valid[lat_idx] <= 1'b1;
               mem_req  <= 1'b0;
               ret_flg  <= 1'b1;
               // Critical word may be the one arriving right now.
               ret_inst <= (cnt == lat_off) ? mem_res : crit;
            end else begin
               cnt      <= cnt_inc;
               mem_addr <= {lat_tag, lat_idx, cnt_inc, 2'b00};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (refill_wr) begin
         data_arr[{lat_idx, cnt}] <= mem_res;
         if (last) tag_arr[lat_idx] <= lat_tag;
      end
   end

`ifdef ICACHE_STAT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (do_hit)  hit_cnt  <= hit_cnt + 32'd1;
         if (do_miss) miss_cnt <= miss_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed + randomized bench for icache_direct against a line-level cache model and backing memory.
module tb_icache_direct;
   logic        clk = 1'b0;
   logic        rst, rdy, reset, if_req, mem_flg;
   logic [31:0] if_addr, mem_res, ret_inst, mem_addr;
   logic        ret_flg, mem_req;
`ifdef ICACHE_STAT_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   always #5 clk = ~clk;

   icache_direct dut (
      .clk(clk), .rst(rst), .rdy(rdy), .reset(reset),
      .if_req(if_req), .if_addr(if_addr),
      .ret_flg(ret_flg), .ret_inst(ret_inst),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_flg(mem_flg), .mem_res(mem_res)
`ifdef ICACHE_STAT_EN
      , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
   );

   int errors = 0;
   int checks = 0;
   int exp_hits = 0;
   int exp_miss = 0;
   bit          mvalid [64];
   logic [21:0] mtag   [64];

   function automatic logic [31:0] bm(input logic [31:0] a);
      case (a)
         32'h0000: return 32'h11;
         32'h0004: return 32'h22;
         32'h0008: return 32'h33;
         32'h000C: return 32'h44;
         32'h1000: return 32'hA0;
         32'h1004: return 32'hA1;
         32'h1008: return 32'hA2;
         32'h100C: return 32'hA3;
         default:  return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic fetch(input logic [31:0] a, input bit gaps);
      logic [31:0] wa, base;
      bit          hit;
      int          n;
      wa   = {a[31:2], 2'b00};
      base = {a[31:4], 4'h0};
      hit  = mvalid[a[9:4]] && (mtag[a[9:4]] == a[31:10]);
      if_req  = 1'b1;
      if_addr = a;
      @(negedge clk);
      if (hit) begin
         exp_hits++;
         check("hit_flg", 32'(ret_flg), 32'd1);
         check("hit_inst", ret_inst, bm(wa));
         check("hit_noreq", 32'(mem_req), 32'd0);
      end else begin
         exp_miss++;
         mvalid[a[9:4]] = 1'b0;
         check("miss_req", 32'(mem_req), 32'd1);
         check("miss_noflg", 32'(ret_flg), 32'd0);
         for (int w = 0; w < 4; w++) begin
            check("refill_addr", mem_addr, base + 32'(4 * w));
            n = gaps ? int'($urandom_range(0, 2)) : 0;
            repeat (n) begin
               if ($urandom_range(0, 1) == 1) begin
                  rdy = 1'b0; mem_flg = 1'b1; mem_res = 32'hBAD0_0000;
               end
               @(negedge clk);
               rdy = 1'b1; mem_flg = 1'b0;
               check("gap_req", 32'(mem_req), 32'd1);
               check("gap_addr", mem_addr, base + 32'(4 * w));
            end
            mem_flg = 1'b1;
            mem_res = bm(base + 32'(4 * w));
            @(negedge clk);
            mem_flg = 1'b0;
         end
         check("fill_flg", 32'(ret_flg), 32'd1);
         check("fill_inst", ret_inst, bm(wa));
         check("fill_req_low", 32'(mem_req), 32'd0);
         mvalid[a[9:4]] = 1'b1;
         mtag[a[9:4]]   = a[31:10];
      end
      // if_req still high: must not be serviced again right after a response
      @(negedge clk);
      check("spacing_flg", 32'(ret_flg), 32'd0);
      check("spacing_req", 32'(mem_req), 32'd0);
      if_req = 1'b0;
   endtask

   task automatic abort_refill(input logic [31:0] a, input int nwords, input bit flg_too);
      logic [31:0] base;
      base = {a[31:4], 4'h0};
      exp_miss++;
      mvalid[a[9:4]] = 1'b0;
      if_req  = 1'b1;
      if_addr = a;
      @(negedge clk);
      check("abort_req", 32'(mem_req), 32'd1);
      for (int w = 0; w < nwords; w++) begin
         mem_flg = 1'b1;
         mem_res = bm(base + 32'(4 * w));
         @(negedge clk);
         mem_flg = 1'b0;
      end
      reset   = 1'b1;
      if_req  = 1'b0;
      mem_flg = flg_too;
      mem_res = 32'hDEAD_BEEF;
      @(negedge clk);
      reset   = 1'b0;
      mem_flg = 1'b0;
      check("abort_req_low", 32'(mem_req), 32'd0);
      check("abort_noflg", 32'(ret_flg), 32'd0);
      @(negedge clk);
      check("abort_noflg2", 32'(ret_flg), 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      rst = 1'b0; rdy = 1'b1; reset = 1'b0; if_req = 1'b0;
      if_addr = '0; mem_flg = 1'b0; mem_res = '0;
      for (int i = 0; i < 64; i++) begin mvalid[i] = 1'b0; mtag[i] = '0; end
      repeat (2) @(negedge clk);
      check("rst_flg", 32'(ret_flg), 32'd0);
      check("rst_inst", ret_inst, 32'd0);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      fetch(32'h0000, 1'b0);   // cold miss, 0x11
      fetch(32'h0008, 1'b0);   // hit, 0x33
      fetch(32'h0400, 1'b0);   // conflicting line
      fetch(32'h0000, 1'b0);   // evicted, misses again
      fetch(32'h100C, 1'b0);   // critical word is the last one
      fetch(32'h0004, 1'b0);   // evict so 0x1000 misses
      abort_refill(32'h1000, 2, 1'b0);
      fetch(32'h1000, 1'b0);   // full refill restarts at 0x1000

      // reset beats a simultaneous hit
      if_req = 1'b1; if_addr = 32'h1004; reset = 1'b1;
      @(negedge clk);
      check("reset_hit_flg", 32'(ret_flg), 32'd0);
      reset = 1'b0; if_req = 1'b0;
      @(negedge clk);
      check("reset_hit_flg2", 32'(ret_flg), 32'd0);

      // rdy low for 3 cycles delays the hit by exactly 3 cycles
      rdy = 1'b0; if_req = 1'b1; if_addr = 32'h1008;
      repeat (3) begin
         @(negedge clk);
         check("stall_flg", 32'(ret_flg), 32'd0);
      end
      rdy = 1'b1;
      @(negedge clk);
      exp_hits++;
      check("stall_hit_flg", 32'(ret_flg), 32'd1);
      check("stall_hit_inst", ret_inst, 32'hA2);
      @(negedge clk);
      check("stall_spacing", 32'(ret_flg), 32'd0);
      if_req = 1'b0;

      // mem_flg coinciding with reset on the last word must not complete the line
      abort_refill(32'h2000, 3, 1'b1);
      fetch(32'h200C, 1'b0);

      for (int i = 0; i < 60; i++) begin
         a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
           | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         fetch(a, 1'b1);
      end

`ifdef ICACHE_STAT_EN
      check("hit_cnt", hit_cnt, 32'(exp_hits));
      check("miss_cnt", miss_cnt, 32'(exp_miss));
`endif

      // async reset invalidates every line and clears outputs
      rst = 1'b0;
      #1;
      check("rst2_req", 32'(mem_req), 32'd0);
      check("rst2_addr", mem_addr, 32'd0);
      check("rst2_inst", ret_inst, 32'd0);
`ifdef ICACHE_STAT_EN
      check("rst2_hit_cnt", hit_cnt, 32'd0);
      check("rst2_miss_cnt", miss_cnt, 32'd0);
`endif
      for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
      exp_hits = 0; exp_miss = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      fetch(32'h0000, 1'b0);
      fetch(32'h0004, 1'b0);
      fetch(32'h0400, 1'b0);
`ifdef ICACHE_STAT_EN
      check("stat_hit_1", hit_cnt, 32'd1);
      check("stat_miss_2", miss_cnt, 32'd2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the IF stage and MemCtl's instruction port.
- Serves IF fetches in 1 cycle on hit.
- On miss it refills a whole line, word by word, through MemCtl.
- The ROB mispredict `reset` aborts a refill in flight; it never invalidates cached lines (no self-modifying code is supported).

Parameters:
- INDEX_BITS, 6, log2 of number of lines (64 lines).
- LINE_WORDS_LOG, 2, log2 of 32-bit words per line (4 words = 16 bytes).
- TAG_BITS, 32-2-LINE_WORDS_LOG-INDEX_BITS, derived tag width; do not override.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- rdy  input  1  global ready; when low all state and outputs freeze.
- reset  input  1  ROB jump/mispredict flush, synchronous, active-high.
- if_req  input  1  IF fetch request; held high with stable if_addr until ret_flg.
- if_addr  input  32  fetch PC, word aligned (bits [1:0] ignored).
- ret_flg  output  1  one-cycle pulse: ret_inst valid for current if_addr.
- ret_inst  output  32  fetched instruction.
- mem_req  output  1  word request to MemCtl; registered, held until mem_flg.
- mem_addr  output  32  byte address of requested word; registered.
- mem_flg  input  1  one-cycle pulse: mem_res holds word at mem_addr.
- mem_res  input  32  returned word.

Behaviour:
- Address split: [1:0] ignored; word offset [LINE_WORDS_LOG+1:2]; index next INDEX_BITS; tag = remaining upper bits.
- Storage: data array, tag array, valid bit per line.
- Reset (rst low, async):
  - all valid bits 0; state IDLE; refill counter 0.
  - ret_flg 0, ret_inst 0, mem_req 0, mem_addr 0.
- rdy low: no register changes; mem_flg and if_req are not sampled.
- Response-spacing rule: ret_flg never asserts two consecutive cycles. The cycle after a response does not sample if_req; IF must change or drop its request on seeing ret_flg.
- FSM IDLE:
  - reset high: ret_flg<=0, stay IDLE.
  - else if_req & !ret_flg & valid & tag match (hit): next cycle ret_flg=1, ret_inst=word. Latency 1.
  - else if_req & !ret_flg & miss:
    - clear valid[index];
    - latch tag, index and word offset;
    - cnt<=0;
    - mem_addr<={if_addr[31:LINE_WORDS_LOG+2], zero offset, 2'b00};
    - mem_req<=1; go REFILL.
- FSM REFILL:
  - On mem_flg (with reset low): write mem_res into data[index][cnt].
  - If cnt equals the latched offset, also capture the word into the critical-word register.
  - If cnt not last: cnt<=cnt+1; mem_addr<=mem_addr+4 (stays within line, never carries into index); mem_req stays 1.
  - If cnt last:
    - write tag, set valid, mem_req<=0;
    - next cycle ret_flg=1, ret_inst=critical word, even when the critical word is the last one just received (forward mem_res);
    - go IDLE.
  - reset high in REFILL: mem_req<=0, ret_flg<=0, valid stays 0, go IDLE. A mem_flg in the same cycle as reset is discarded.
- Simultaneous reset and hit: reset wins, no response.
- The IF request is not re-checked at refill completion: IF holds the address during a miss unless reset, which aborts the refill.
- Instruction fetches never target I/O space (>=0x30000); no special handling.

Optional Feature:
- Macro ICACHE_STAT_EN.
- Defined: adds outputs hit_cnt [31:0] and miss_cnt [31:0].
  - hit_cnt increments on each hit response.
  - miss_cnt increments on each IDLE->REFILL transition.
  - Both counters are frozen while rdy is low and cleared to 0 by rst; reset does not clear them; they wrap modulo 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Cold miss, if_addr=0x0, mem returns 0x11,0x22,0x33,0x44 -> mem_addr 0x0,0x4,0x8,0xC; mem_req low after 4th mem_flg; ret_flg with ret_inst=0x11 one cycle after 4th mem_flg.
- Then if_addr=0x8 -> ret_flg next cycle, ret_inst=0x33, mem_req stays 0.
- Conflict at default params, if_addr=0x400 -> full refill from 0x400..0x40C. A following if_addr=0x0 misses again.
- Miss at if_addr=0x100C with words 0xA0..0xA3 -> response ret_inst=0xA3 forwarded in the cycle after last mem_flg.
- reset pulsed after 2nd mem_flg of refill for 0x1000 -> mem_req 0 next cycle, no ret_flg. Re-request 0x1000 -> mem_addr restarts at 0x1000, all 4 words fetched.
- rdy low for 3 cycles while hit pending -> ret_flg delayed exactly 3 cycles.
- With ICACHE_STAT_EN: miss 0x0, hit 0x4, miss 0x400 -> hit_cnt=1, miss_cnt=2; rst low -> both 0.
